// File: rtl/cross_term_accumulator.sv
// Pairs signed ALU products into cross terms (P_a - P_b). SIGN mode returns one cross term;
// AREA mode accumulates N_TERMS of them and returns |sum|>>1 with sign/zero flags.
module cross_term_accumulator #(
  parameter  int DATA_WIDTH = 64,
  parameter  int N_TERMS    = 6,
  localparam int PROD_W     = 2 * DATA_WIDTH,
  localparam int ACC_W      = PROD_W + 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     prod_valid,
  input  logic signed [PROD_W-1:0] prod_in,
  output logic                     prod_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [ACC_W-1:0]  result,
  output logic                     neg,
  output logic                     zero,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_SECOND,
    S_FINISH,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(N_TERMS - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_mode;
  logic signed [PROD_W-1:0]  r_pa;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [3:0]         r_cnt;
  logic        [ACC_W-1:0]   r_result;
  logic                      r_neg;
  logic                      r_zero;
  logic                      w_xfer;
  logic signed [ACC_W-1:0]   w_cross;

  // Difference is formed one bit wider than the products so it can never overflow.
  function automatic logic signed [ACC_W-1:0] f_cross(input logic signed [PROD_W-1:0] a,
                                                      input logic signed [PROD_W-1:0] b);
    logic [PROD_W:0] d;
    d = {a[PROD_W-1], a} - {b[PROD_W-1], b};
    return {{(ACC_W - PROD_W - 1){d[PROD_W]}}, d};
  endfunction

  function automatic logic [ACC_W-1:0] f_abs_half(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] m;
    m = v[ACC_W-1] ? -v : v;
    return m >> 1;
  endfunction

  assign prod_ready = (r_state == S_FIRST) || (r_state == S_SECOND);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign result     = r_result;
  assign neg        = r_neg;
  assign zero       = r_zero;
  assign w_xfer     = prod_valid && prod_ready;
  assign w_cross    = f_cross(r_pa, prod_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FIRST;
      S_FIRST:  if (w_xfer) w_next = S_SECOND;
      S_SECOND: begin
        if (w_xfer) begin
          if (!r_mode)                w_next = S_DONE;
          else if (r_cnt == LAST_CNT) w_next = S_FINISH;
          else                        w_next = S_FIRST;
        end
      end
      S_FINISH: w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= 1'b0;
      r_pa     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        S_FIRST: if (w_xfer) r_pa <= prod_in;
        S_SECOND: begin
          if (w_xfer) begin
            if (!r_mode) begin
              r_result <= w_cross;
              r_neg    <= w_cross[ACC_W-1];
              r_zero   <= (w_cross == '0);
            end else begin
              r_acc <= r_acc + w_cross;
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        // Flags come from the signed sum; the result itself is the halved magnitude.
        S_FINISH: begin
          r_neg    <= r_acc[ACC_W-1];
          r_zero   <= (r_acc == '0);
          r_result <= f_abs_half(r_acc);
        end
        default: ;
      endcase
    end
  end

endmodule
